// File: rtl/bus_datapath_p.sv
// Single-bus datapath: source-select bus mux, register file, ALU with N/Z/C flags,
// program counter and a request/acknowledge memory interface with wait-state support.
module bus_datapath_p #(
    parameter int unsigned           WIDTH    = 8,
    parameter int unsigned           NUM_REGS = 4,
    parameter logic [WIDTH-1:0]      PC_RESET = '0,
    localparam int unsigned          SEL_W    = $clog2(NUM_REGS)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_uopValid,
    output logic             o_uopReady,
    input  logic [2:0]       i_busSrc,
    input  logic [WIDTH-1:0] i_immediate,
    input  logic             i_regWrEn,
    input  logic [SEL_W-1:0] i_regWrSel,
    input  logic [SEL_W-1:0] i_regBusSel,
    input  logic [SEL_W-1:0] i_regAluSel,
    input  logic [1:0]       i_aluOp,
    input  logic             i_aluSubShiftDir,
    input  logic             i_aluWr,
    input  logic             i_pcLoad,
    input  logic             i_pcIncr,
    input  logic             i_memAddrEn,
    input  logic             i_memRead,
    input  logic             i_memWrite,
    output logic             o_memReq,
    output logic             o_memWe,
    output logic [WIDTH-1:0] o_memAddr,
    output logic [WIDTH-1:0] o_memWData,
    input  logic             i_memAck,
    input  logic [WIDTH-1:0] i_memRData,
    output logic             o_flagN,
    output logic             o_flagZ,
    output logic             o_flagC,
    output logic [WIDTH-1:0] o_bus,
    output logic [WIDTH-1:0] o_pc
);

    typedef enum logic [0:0] {
        Idle    = 1'b0,
        MemWait = 1'b1
    } memState_t;

    memState_t        state;
    memState_t        stateNext;
    logic [WIDTH-1:0] regFile [NUM_REGS];
    logic [WIDTH-1:0] aluResult;
    logic [WIDTH-1:0] memData;
    logic [WIDTH-1:0] aluA;
    logic [WIDTH:0]   aluWide;
    logic             accept;

    assign accept = i_uopValid & o_uopReady;
    assign aluA   = regFile[i_regAluSel];

    // Shared bus source select
    always_comb begin
        o_bus = '0;
        case (i_busSrc)
            3'd1:    o_bus = aluResult;
            3'd2:    o_bus = regFile[i_regBusSel];
            3'd3:    o_bus = memData;
            3'd4:    o_bus = o_pc;
            3'd5:    o_bus = i_immediate;
            default: o_bus = '0;
        endcase
    end

    // ALU: top bit of aluWide is carry, borrow (A < B) or shifted-out bit
    always_comb begin
        aluWide = '0;
        case (i_aluOp)
            2'b00: begin
                if (i_aluSubShiftDir) aluWide = {1'b0, aluA} - {1'b0, o_bus};
                else                  aluWide = {1'b0, aluA} + {1'b0, o_bus};
            end
            2'b01: aluWide = {1'b0, aluA & o_bus};
            2'b10: aluWide = {1'b0, aluA | o_bus};
            default: begin
                if (i_aluSubShiftDir) aluWide = {aluA[0], 1'b0, aluA[WIDTH-1:1]};
                else                  aluWide = {aluA, 1'b0};
            end
        endcase
    end

    // Memory transaction next state
    always_comb begin
        stateNext = state;
        case (state)
            Idle:    if (accept && (i_memRead || i_memWrite)) stateNext = MemWait;
            MemWait: if (i_memAck) stateNext = Idle;
            default: stateNext = Idle;
        endcase
    end

    // State register with registered handshake outputs
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state      <= Idle;
            o_memReq   <= 1'b0;
            o_uopReady <= 1'b1;
        end else begin
            state      <= stateNext;
            o_memReq   <= (stateNext == MemWait);
            o_uopReady <= (stateNext == Idle);
        end
    end

    // Datapath registers; micro-op effects only on an accepting edge
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            regFile     <= '{default: '0};
            aluResult   <= '0;
            memData     <= '0;
            o_memAddr   <= '0;
            o_memWData  <= '0;
            o_memWe     <= 1'b0;
            o_flagN     <= 1'b0;
            o_flagZ     <= 1'b0;
            o_flagC     <= 1'b0;
            o_pc        <= PC_RESET;
        end else begin
            if (accept) begin
                if (i_regWrEn) regFile[i_regWrSel] <= o_bus;
                if (i_aluWr) begin
                    aluResult <= aluWide[WIDTH-1:0];
                    o_flagN   <= aluWide[WIDTH-1];
                    o_flagZ   <= (aluWide[WIDTH-1:0] == '0);
                    o_flagC   <= aluWide[WIDTH];
                end
                if (i_pcLoad)      o_pc <= o_bus;
                else if (i_pcIncr) o_pc <= o_pc + WIDTH'(1);
                if (i_memAddrEn) o_memAddr <= o_bus;
                if (i_memWrite) begin
                    o_memWData <= o_bus;
                    o_memWe    <= 1'b1;
                end else if (i_memRead) begin
                    o_memWe    <= 1'b0;
                end
            end
            if (state == MemWait && i_memAck && !o_memWe) memData <= i_memRData;
        end
    end

endmodule

// File: tb/tb_bus_datapath_p.sv
// Self-checking bench for bus_datapath_p: directed vector table, memory handshake
// sequences and randomized micro-ops against an arithmetic reference model.
module tb_bus_datapath_p;

    localparam int unsigned WIDTH    = 8;
    localparam int unsigned NUM_REGS = 4;
    localparam logic [7:0]  PC_RST   = 8'h10;

    typedef struct {
        logic       valid;
        logic [2:0] busSrc;
        logic [7:0] imm;
        logic       regWrEn;
        logic [1:0] wrSel;
        logic [1:0] busSel;
        logic [1:0] aluSel;
        logic [1:0] aluOp;
        logic       dir;
        logic       aluWr;
        logic       pcLoad;
        logic       pcIncr;
        logic       memAddrEn;
        logic       memRead;
        logic       memWrite;
    } uop_t;

    typedef struct {
        uop_t u;
        int   expBus;
        int   expPc;
        int   expN;
        int   expZ;
        int   expC;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       uopValid = 1'b0;
    logic       uopReady;
    logic [2:0] busSrc = '0;
    logic [7:0] imm = '0;
    logic       regWrEn = 1'b0;
    logic [1:0] regWrSel = '0, regBusSel = '0, regAluSel = '0;
    logic [1:0] aluOp = '0;
    logic       aluDir = 1'b0, aluWr = 1'b0;
    logic       pcLoad = 1'b0, pcIncr = 1'b0, memAddrEn = 1'b0;
    logic       memRead = 1'b0, memWrite = 1'b0;
    logic       memReq, memWe, memAck = 1'b0;
    logic [7:0] memAddr, memWData, memRData = '0;
    logic       flagN, flagZ, flagC;
    logic [7:0] bus, pc;

    int passCnt = 0;
    int totalCnt = 0;

    int mRegs [NUM_REGS];
    int mAlu, mData, mAddr, mWData, mPc;
    int mN, mZ, mC, mWe, mBusy;

    vec_t tbl[$];

    bus_datapath_p #(.WIDTH(WIDTH), .NUM_REGS(NUM_REGS), .PC_RESET(PC_RST)) dut (
        .i_clk(clk), .i_reset(reset), .i_uopValid(uopValid), .o_uopReady(uopReady),
        .i_busSrc(busSrc), .i_immediate(imm), .i_regWrEn(regWrEn), .i_regWrSel(regWrSel),
        .i_regBusSel(regBusSel), .i_regAluSel(regAluSel), .i_aluOp(aluOp),
        .i_aluSubShiftDir(aluDir), .i_aluWr(aluWr), .i_pcLoad(pcLoad), .i_pcIncr(pcIncr),
        .i_memAddrEn(memAddrEn), .i_memRead(memRead), .i_memWrite(memWrite),
        .o_memReq(memReq), .o_memWe(memWe), .o_memAddr(memAddr), .o_memWData(memWData),
        .i_memAck(memAck), .i_memRData(memRData), .o_flagN(flagN), .o_flagZ(flagZ),
        .o_flagC(flagC), .o_bus(bus), .o_pc(pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        totalCnt++;
        if (act == exp) passCnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic uop_t nop();
        uop_t u;
        u = '{default: '0};
        u.valid = 1'b1;
        return u;
    endfunction

    function automatic int modelBus();
        case (busSrc)
            3'd1:    return mAlu;
            3'd2:    return mRegs[regBusSel];
            3'd3:    return mData;
            3'd4:    return mPc;
            3'd5:    return int'(imm);
            default: return 0;
        endcase
    endfunction

    task automatic modelReset();
        foreach (mRegs[i]) mRegs[i] = 0;
        mAlu = 0; mData = 0; mAddr = 0; mWData = 0; mPc = int'(PC_RST);
        mN = 0; mZ = 0; mC = 0; mWe = 0; mBusy = 0;
    endtask

    // Reference behaviour for one clock edge, from the current inputs
    task automatic modelEdge();
        int a, b, res, c, s;
        b = modelBus();
        a = mRegs[regAluSel];
        res = 0; c = 0;
        if (reset) begin
            modelReset();
        end else if (mBusy != 0) begin
            if (memAck) begin
                if (mWe == 0) mData = int'(memRData);
                mBusy = 0;
            end
        end else if (uopValid) begin
            if (aluWr) begin
                case (aluOp)
                    2'b00: begin
                        if (aluDir) begin res = (a - b + 256) % 256; c = (a < b) ? 1 : 0; end
                        else begin s = a + b; res = s % 256; c = (s > 255) ? 1 : 0; end
                    end
                    2'b01: res = a & b;
                    2'b10: res = a | b;
                    default: begin
                        if (aluDir) begin res = a / 2; c = a % 2; end
                        else begin res = (a * 2) % 256; c = a / 128; end
                    end
                endcase
                mAlu = res; mN = (res >= 128) ? 1 : 0; mZ = (res == 0) ? 1 : 0; mC = c;
            end
            if (regWrEn) mRegs[regWrSel] = b;
            if (pcLoad) mPc = b;
            else if (pcIncr) mPc = (mPc + 1) % 256;
            if (memAddrEn) mAddr = b;
            if (memWrite) begin mWData = b; mWe = 1; mBusy = 1; end
            else if (memRead) begin mWe = 0; mBusy = 1; end
        end
    endtask

    task automatic pre(input uop_t u, input logic ack, input logic [7:0] rd, input logic rst);
        uopValid = u.valid; busSrc = u.busSrc; imm = u.imm; regWrEn = u.regWrEn;
        regWrSel = u.wrSel; regBusSel = u.busSel; regAluSel = u.aluSel; aluOp = u.aluOp;
        aluDir = u.dir; aluWr = u.aluWr; pcLoad = u.pcLoad; pcIncr = u.pcIncr;
        memAddrEn = u.memAddrEn; memRead = u.memRead; memWrite = u.memWrite;
        memAck = ack; memRData = rd; reset = rst;
        #1;
        chk("bus", int'(bus), modelBus());
    endtask

    task automatic post();
        @(posedge clk);
        modelEdge();
        #1;
        chk("pc", int'(pc), mPc);
        chk("flags", int'({flagN, flagZ, flagC}), mN * 4 + mZ * 2 + mC);
        chk("req", int'(memReq), mBusy);
        chk("ready", int'(uopReady), 1 - mBusy);
        chk("memWe", int'(memWe), mWe);
        chk("memAddr", int'(memAddr), mAddr);
        chk("memWData", int'(memWData), mWData);
    endtask

    function automatic uop_t immWr(input logic [7:0] v, input logic [1:0] sel);
        uop_t u = nop();
        u.busSrc = 3'd5; u.imm = v; u.regWrEn = 1'b1; u.wrSel = sel;
        return u;
    endfunction

    function automatic uop_t aluU(input logic [1:0] op, input logic d, input logic [1:0] aSel,
                                  input logic [2:0] src, input logic [7:0] v, input logic [1:0] bSel);
        uop_t u = nop();
        u.aluOp = op; u.dir = d; u.aluSel = aSel; u.aluWr = 1'b1;
        u.busSrc = src; u.imm = v; u.busSel = bSel;
        return u;
    endfunction

    task automatic addVec(input uop_t u, input int eb, input int ep, input int en, input int ez, input int ec);
        vec_t v;
        v.u = u; v.expBus = eb; v.expPc = ep; v.expN = en; v.expZ = ez; v.expC = ec;
        tbl.push_back(v);
    endtask

    initial begin
        uop_t u;

        // Directed vectors: bus value before the edge, PC and flags after it
        addVec(immWr(8'h7F, 2'd1), 'h7F, 'h10, 0, 0, 0);
        addVec(immWr(8'h01, 2'd0), 'h01, 'h10, 0, 0, 0);
        addVec(aluU(2'b00, 1'b0, 2'd1, 3'd2, 8'h00, 2'd0), 'h01, 'h10, 1, 0, 0);
        u = nop(); u.busSrc = 3'd1;  addVec(u, 'h80, 'h10, 1, 0, 0);
        addVec(immWr(8'h03, 2'd2), 'h03, 'h10, 1, 0, 0);
        addVec(aluU(2'b00, 1'b1, 2'd2, 3'd5, 8'h05, 2'd0), 'h05, 'h10, 1, 0, 1);
        u = nop(); u.busSrc = 3'd1;  addVec(u, 'hFE, 'h10, 1, 0, 1);
        addVec(immWr(8'h05, 2'd2), 'h05, 'h10, 1, 0, 1);
        addVec(aluU(2'b00, 1'b1, 2'd2, 3'd5, 8'h05, 2'd0), 'h05, 'h10, 0, 1, 0);
        u = nop(); u.busSrc = 3'd1;  addVec(u, 'h00, 'h10, 0, 1, 0);
        u = nop(); u.busSrc = 3'd5; u.imm = 8'h42; u.pcLoad = 1'b1; u.pcIncr = 1'b1;
        addVec(u, 'h42, 'h42, 0, 1, 0);
        u = nop(); u.busSrc = 3'd5; u.imm = 8'hFF; u.pcLoad = 1'b1;
        addVec(u, 'hFF, 'hFF, 0, 1, 0);
        u = nop(); u.busSrc = 3'd4; u.pcIncr = 1'b1;
        addVec(u, 'hFF, 'h00, 0, 1, 0);
        addVec(aluU(2'b11, 1'b0, 2'd1, 3'd0, 8'h00, 2'd0), 'h00, 'h00, 1, 0, 0);
        addVec(aluU(2'b11, 1'b1, 2'd0, 3'd0, 8'h00, 2'd0), 'h00, 'h00, 0, 1, 1);
        addVec(aluU(2'b01, 1'b0, 2'd1, 3'd5, 8'h80, 2'd0), 'h80, 'h00, 0, 1, 0);
        addVec(aluU(2'b10, 1'b0, 2'd1, 3'd5, 8'h80, 2'd0), 'h80, 'h00, 1, 0, 0);
        addVec(aluU(2'b00, 1'b0, 2'd1, 3'd5, 8'h81, 2'd0), 'h81, 'h00, 0, 1, 1);
        u = immWr(8'h99, 2'd0); u.valid = 1'b0; u.pcIncr = 1'b1; u.aluWr = 1'b1;
        addVec(u, 'h99, 'h00, 0, 1, 1);
        u = nop(); u.busSrc = 3'd2; u.busSel = 2'd0;
        addVec(u, 'h01, 'h00, 0, 1, 1);

        // Reset state
        reset = 1'b1;
        repeat (2) @(posedge clk);
        modelReset();
        #1;
        chk("rstPc", int'(pc), 'h10);
        chk("rstFlags", int'({flagN, flagZ, flagC}), 0);
        chk("rstReady", int'(uopReady), 1);
        chk("rstReq", int'(memReq), 0);

        foreach (tbl[i]) begin
            pre(tbl[i].u, 1'b0, 8'h00, 1'b0);
            chk($sformatf("vec%0d.bus", i), int'(bus), tbl[i].expBus);
            post();
            chk($sformatf("vec%0d.pc", i), int'(pc), tbl[i].expPc);
            chk($sformatf("vec%0d.nzc", i), int'({flagN, flagZ, flagC}),
                tbl[i].expN * 4 + tbl[i].expZ * 2 + tbl[i].expC);
        end

        // Read with three wait cycles; valid held high meanwhile must do nothing
        u = nop(); u.busSrc = 3'd5; u.imm = 8'h20; u.memAddrEn = 1'b1; u.memRead = 1'b1;
        pre(u, 1'b0, 8'h00, 1'b0);
        post();
        chk("rdAddr", int'(memAddr), 'h20);
        chk("rdReq", int'(memReq), 1);
        chk("rdReady", int'(uopReady), 0);
        u = immWr(8'h77, 2'd3); u.pcIncr = 1'b1; u.aluWr = 1'b1; u.memWrite = 1'b1;
        for (int k = 0; k < 3; k++) begin
            pre(u, 1'b0, 8'h00, 1'b0);
            post();
            chk("rdWaitReq", int'(memReq), 1);
            chk("rdWaitPc", int'(pc), 'h00);
        end
        u = nop(); u.valid = 1'b0;
        pre(u, 1'b1, 8'hA5, 1'b0);
        post();
        chk("rdDoneReq", int'(memReq), 0);
        chk("rdDoneReady", int'(uopReady), 1);
        u = nop(); u.busSrc = 3'd3;
        pre(u, 1'b0, 8'h00, 1'b0);
        chk("rdData", int'(bus), 'hA5);
        post();
        u = nop(); u.busSrc = 3'd2; u.busSel = 2'd3;
        pre(u, 1'b0, 8'h00, 1'b0);
        chk("rdNoWr", int'(bus), 'h00);
        post();

        // Write, then reset during the wait, then a stray ack
        u = nop(); u.busSrc = 3'd5; u.imm = 8'h3C; u.memWrite = 1'b1; u.memRead = 1'b1;
        pre(u, 1'b0, 8'h00, 1'b0);
        post();
        chk("wrData", int'(memWData), 'h3C);
        chk("wrWe", int'(memWe), 1);
        chk("wrReq", int'(memReq), 1);
        u = nop(); u.valid = 1'b0;
        pre(u, 1'b0, 8'h00, 1'b0);
        post();
        pre(u, 1'b0, 8'h00, 1'b1);
        post();
        chk("abortReq", int'(memReq), 0);
        chk("abortReady", int'(uopReady), 1);
        chk("abortPc", int'(pc), 'h10);
        pre(u, 1'b1, 8'h5A, 1'b0);
        post();
        chk("strayReq", int'(memReq), 0);
        u = nop(); u.busSrc = 3'd3;
        pre(u, 1'b0, 8'h00, 1'b0);
        chk("strayData", int'(bus), 'h00);
        post();

        // Randomized micro-ops against the reference model
        for (int n = 0; n < 600; n++) begin
            u.valid     = ($urandom_range(0, 3) != 0);
            u.busSrc    = 3'($urandom_range(0, 7));
            u.imm       = 8'($urandom);
            u.regWrEn   = 1'($urandom);
            u.wrSel     = 2'($urandom);
            u.busSel    = 2'($urandom);
            u.aluSel    = 2'($urandom);
            u.aluOp     = 2'($urandom);
            u.dir       = 1'($urandom);
            u.aluWr     = 1'($urandom);
            u.pcLoad    = ($urandom_range(0, 7) == 0);
            u.pcIncr    = 1'($urandom);
            u.memAddrEn = 1'($urandom);
            u.memRead   = ($urandom_range(0, 7) == 0);
            u.memWrite  = ($urandom_range(0, 7) == 0);
            pre(u, (mBusy != 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0),
                8'($urandom), ($urandom_range(0, 63) == 0));
            post();
        end

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule

// File: doc/bus_datapath_p.md
Name: bus_datapath_p

Overview:
Parametrised successor to the 8-bit single-bus datapath. It holds the shared bus, register file, ALU result/flag registers, program counter and memory address/data registers. The shared bus becomes an explicit source-select mux rather than multiple drivers. Register count and data width are generalised, and a carry flag is added. Memory access is now a multi-cycle request/acknowledge handshake, so wait-stated memory works. The block is driven one micro-op per cycle by the control unit over a valid/ready handshake.

Parameters:
WIDTH, 8, data/bus/address width in bits (>=4).
NUM_REGS, 4, general registers (power of two, >=2). SEL_W = clog2(NUM_REGS) is a derived localparam.
PC_RESET, 0, PC value loaded on reset.

Ports:
i_clk  in  1  clock, rising edge.
i_reset  in  1  synchronous, active-high reset.
i_uopValid  in  1  micro-op fields are valid this cycle.
o_uopReady  out  1  datapath accepts a micro-op. Accepted = i_uopValid & o_uopReady.
i_busSrc  in  3  bus source: 0 zero, 1 ALU result, 2 reg[i_regBusSel], 3 mem data reg, 4 PC, 5 i_immediate, 6-7 zero.
i_immediate  in  WIDTH  immediate operand from control.
i_regWrEn  in  1  write bus into reg[i_regWrSel].
i_regWrSel / i_regBusSel / i_regAluSel  in  SEL_W  write target / bus read port / ALU A-operand port.
i_aluOp  in  2  00 add/sub, 01 and, 10 or, 11 shift.
i_aluSubShiftDir  in  1  op 00: 1 = subtract. Op 11: 1 = shift right.
i_aluWr  in  1  latch ALU result and flags.
i_pcLoad / i_pcIncr  in  1  load PC from bus / increment PC.
i_memAddrEn  in  1  latch bus into memory address register.
i_memRead / i_memWrite  in  1  start a memory read / write transaction.
o_memReq  out  1  memory request.
o_memWe  out  1  1 = write transaction.
o_memAddr / o_memWData  out  WIDTH  address / write data registers.
i_memAck  in  1  memory completes the transaction.
i_memRData  in  WIDTH  read data, valid when i_memAck is high.
o_flagN / o_flagZ / o_flagC  out  1  ALU flags (registered).
o_bus  out  WIDTH  current bus value (combinational).
o_pc  out  WIDTH  program counter.

Behaviour:
- Reset clears all registers, ALU result, memory address/data/write-data registers, and N/Z/C to 0. PC is set to PC_RESET. FSM goes to IDLE. o_memReq = 0, o_memWe = 0, o_uopReady = 1 in the cycle after the reset edge.
- Bus: combinational mux of registered sources selected by i_busSrc. It carries a value regardless of valid. Every write effect samples this same-cycle bus value.
- Micro-op fields are ignored unless the micro-op is accepted. All side effects take place at the accepting clock edge.
- Register file: a write and a bus read of the same register in one cycle puts the old value on the bus. The new value is visible from the next cycle.
- ALU operands and results:
  - A = reg[i_regAluSel], B = bus.
  - Add: C = carry-out.
  - Sub: A-B mod 2^WIDTH, C = 1 when A < B unsigned.
  - And/or: C = 0.
  - Shift: by 1, zero-fill. Left: C = A[WIDTH-1]. Right: C = A[0]. B is unused.
  - On aluWr: N = result MSB, Z = (result == 0). ALU result and flags hold otherwise.
- PC: load has priority over increment. Increment wraps from 2^WIDTH-1 to 0.
- Memory FSM, IDLE -> MEM_WAIT -> IDLE:
  - In IDLE, an accepted micro-op with memRead or memWrite enters MEM_WAIT.
  - memWrite latches the bus into o_memWData and sets o_memWe = 1. memRead sets o_memWe = 0.
  - If both are set, write wins and read is ignored.
  - Other fields of the same micro-op execute normally. This includes memAddrEn, whose newly latched address is the transaction address.
  - In MEM_WAIT: o_memReq = 1, o_uopReady = 0.
  - On i_memAck: a read latches i_memRData into the mem data register. FSM returns to IDLE, o_memReq drops the next cycle, o_uopReady = 1.
  - Minimum transaction length is 1 wait cycle. An ack arriving the same cycle req first rises completes it.
  - An ack while IDLE is ignored.
- Reset mid-transaction aborts it: FSM to IDLE, no data latched.

Test Plan:
- Reset: PC_RESET = 8'h10 -> o_pc = 8'h10, flags 0, o_uopReady = 1, o_memReq = 0.
- Load/add: imm 8'h7F -> r1; imm 8'h01 -> r0; ALU add with A = r1, bus = reg r0, aluWr; then busSrc = 1 -> bus = 8'h80, N = 1, Z = 0, C = 0.
- Sub/borrow: r2 = 8'h03, bus imm 8'h05, sub -> result 8'hFE, C = 1, N = 1. Then 5-5 -> result 0, Z = 1, C = 0.
- PC: pcLoad and pcIncr together with bus 8'h42 -> o_pc = 8'h42. PC 8'hFF with incr -> 8'h00.
- Memory read with 3 wait cycles: memAddrEn and memRead with bus 8'h20 -> o_memAddr = 8'h20, req high and ready low until ack with rdata 8'hA5; busSrc = 3 then shows 8'hA5. A valid held high during the wait causes no side effects.
- Write then reset: memWrite with bus 8'h3C -> o_memWData = 8'h3C, o_memWe = 1. Reset asserted during the wait -> req = 0 and ready = 1 after the edge. A later stray ack is ignored.
